mcast_fork_ctl: RTL
===================

// Module: mcast_fork_ctl
// PURPOSE
//  Per-input-port multicast fork controller. Takes head flit destination mask, requests every destination
//  output arbiter, gathers and holds all grants, then streams the packet to all destinations in lockstep.
//  Sits between an input buffer and the five output mux controllers. Timeout/backoff releases partial grants
//  so two multicast packets with overlapping masks cannot deadlock.
// PARAMETERS
//  NPORT    5   number of router ports (mask/request/grant width)
//  TIMEOUT  16  GATHER cycles with incomplete grant set before partial grants are released (>=1)
//  BACKOFF  4   base IDLE-request-suppression cycles after a timeout (>=1)
//  CNTW     6   width of timeout/backoff counters; must hold max(TIMEOUT, BACKOFF*8)
// PORTS
//  clk         in   1      clock
//  rst_        in   1      synchronous reset, active low
//  in_valid    in   1      input buffer has a flit at its head
//  in_head     in   1      head-of-buffer flit is a head flit
//  in_tail     in   1      head-of-buffer flit is a tail flit (head&tail = single-flit packet)
//  in_dmask    in   NPORT  destination mask; sampled only with a valid head flit in IDLE
//  grt_in      in   NPORT  grant from each output's mux controller for this input
//  out_rdy     in   NPORT  per-output downstream credit available this cycle
//  req_out     out  NPORT  request to each output's mux controller
//  multab_out  out  1      high while the latched mask has >=2 bits set (multicast)
//  in_pop      out  1      dequeue the head-of-buffer flit this cycle
//  out_send    out  NPORT  per-output flit-transfer strobe (crossbar enable)
//  busy        out  1      state != IDLE
//  err_flit    out  1      1-cycle pulse: non-head flit or zero mask seen in IDLE
// BEHAVIOUR
//  Reset (rst_==0 at posedge): state=IDLE, mask=0, got=0, counters=0, retry=0; all outputs 0.
//  States: IDLE, GATHER, XFER, BACKOFF (2-bit encoding, IDLE=0).
//  IDLE: if in_valid & in_head & in_dmask!=0 -> latch mask, got=0, tcnt=0, -> GATHER next cycle.
//   in_valid & (!in_head | in_dmask==0): pop flit (in_pop=1), pulse err_flit, stay IDLE (drop).
//  GATHER: req_out = mask. got |= grt_in & mask each cycle (grant held by arbiter while req held).
//   (got|(grt_in&mask))==mask -> XFER next cycle, tcnt=0. Else tcnt++;
//   tcnt==TIMEOUT-1 and got!=0 -> BACKOFF, req_out=0 next cycle, got=0, retry++ (saturates at 3).
//   tcnt==TIMEOUT-1 and got==0 -> tcnt=0, stay GATHER (no grant held, no deadlock risk).
//  BACKOFF: req_out=0 for BACKOFF<<retry cycles (4,8,16,32 default), then -> GATHER, tcnt=0.
//  XFER: req_out=mask (hold grants). fire = in_valid & (&(out_rdy|~mask)) & (&(grt_in|~mask)).
//   fire: in_pop=1, out_send=mask, same cycle. No fire: in_pop=0, out_send=0 (lockstep, no partial send).
//   fire & in_tail -> IDLE next cycle, req_out=0, mask=0, retry=0. Head+tail packet: one fire then IDLE.
//   Grant lost in XFER (grt_in&mask != mask): stall; never sends to a subset.
//  multab_out = ($countones(mask)>=2) in GATHER/XFER, else 0.
//  Latency: head flit in IDLE -> req_out next cycle; all grants in cycle N -> first out_send earliest N+1.
//  in_dmask changes outside IDLE are ignored. Reset mid-packet: all requests drop next edge, flit not popped.
//  Counters never wrap: tcnt cleared at TIMEOUT-1, backoff count compared to exact limit.
// TESTING
//  Unicast 3-flit pkt, mask=00100, grant 1 cycle after req, out_rdy=all1 -> 3 consecutive out_send=00100, IDLE.
//  Mcast mask=10011, grants arrive cycles 1,3,5 -> XFER after 3rd; each body flit out_send=10011 only.
//  Mcast mask=00110, out_rdy[2] low 4 cycles mid-packet -> no in_pop/out_send those cycles, then resume.
//  Only grt_in[1] held of mask=00011 for TIMEOUT -> req_out=0 for 4, then 8 on 2nd timeout; retry reset after tail.
//  IDLE with in_head=0 or in_dmask=0 -> in_pop=1, err_flit 1 cycle, no req_out.
//  rst_ low in XFER mid-packet -> next cycle req_out=0, out_send=0, state IDLE, busy=0.

Source files
------------

// File: rtl/mcast_fork_ctl_if.sv
// rtl/mcast_fork_ctl_if.sv - handshake bundle between input buffer, output arbiters and the multicast fork controller
interface mcast_fork_ctl_if #(
  parameter int NPORT = 5
);
  logic             in_valid;
  logic             in_head;
  logic             in_tail;
  logic [NPORT-1:0] in_dmask;
  logic [NPORT-1:0] grt_in;
  logic [NPORT-1:0] out_rdy;
  logic [NPORT-1:0] req_out;
  logic             multab_out;
  logic             in_pop;
  logic [NPORT-1:0] out_send;
  logic             busy;
  logic             err_flit;

  // Environment side: input buffer, arbiters and downstream credit
  modport master (
    output in_valid, in_head, in_tail, in_dmask, grt_in, out_rdy,
    input  req_out, multab_out, in_pop, out_send, busy, err_flit
  );

  // Controller side
  modport slave (
    input  in_valid, in_head, in_tail, in_dmask, grt_in, out_rdy,
    output req_out, multab_out, in_pop, out_send, busy, err_flit
  );
endinterface

// File: rtl/mcast_fork_ctl.sv
// rtl/mcast_fork_ctl.sv - per-input multicast fork controller: gather all grants, stream in lockstep, back off on timeout
module mcast_fork_ctl #(
  parameter int NPORT   = 5,
  parameter int TIMEOUT = 16,
  parameter int BACKOFF = 4,
  parameter int CNTW    = 6
) (
  input  logic            clk,
  input  logic            rst_,
  mcast_fork_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GATHER  = 2'd1,
    S_XFER    = 2'd2,
    S_BACKOFF = 2'd3
  } state_t;

  localparam logic [CNTW-1:0] TLAST = CNTW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [NPORT-1:0] mask_q, mask_d;
  logic [NPORT-1:0] got_q, got_d;
  logic [CNTW-1:0]  tcnt_q, tcnt_d;
  logic [CNTW-1:0]  bcnt_q, bcnt_d;
  logic [CNTW-1:0]  blim_q, blim_d;
  logic [1:0]       retry_q, retry_d;

  logic [NPORT-1:0] got_upd;
  logic             fire;
  logic [NPORT-1:0] req_c;
  logic [NPORT-1:0] send_c;
  logic             pop_c;
  logic             err_c;

  // Grants accumulate while requesting; a flit moves only when every destination is granted and has credit
  assign got_upd = got_q | (bus.grt_in & mask_q);
  assign fire    = bus.in_valid & (&(bus.out_rdy | ~mask_q)) & (&(bus.grt_in | ~mask_q));

  // State, mask and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      got_q   <= '0;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      blim_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      got_q   <= got_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      blim_q  <= blim_d;
      retry_q <= retry_d;
    end
  end

  // Next-state and per-cycle strobes
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    got_d   = got_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    blim_d  = blim_q;
    retry_d = retry_q;
    req_c   = '0;
    send_c  = '0;
    pop_c   = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_head && (|bus.in_dmask)) begin
            mask_d  = bus.in_dmask;
            got_d   = '0;
            tcnt_d  = '0;
            state_d = S_GATHER;
          end else begin
            // Stray body flit or empty mask: drop it so the buffer cannot wedge
            pop_c = 1'b1;
            err_c = 1'b1;
          end
        end
      end
      S_GATHER: begin
        req_c = mask_q;
        got_d = got_upd;
        if (got_upd == mask_q) begin
          state_d = S_XFER;
          tcnt_d  = '0;
        end else if (tcnt_q == TLAST) begin
          tcnt_d = '0;
          // Only a partial holder can deadlock another packet; with nothing held just keep asking
          if (|got_upd) begin
            state_d = S_BACKOFF;
            got_d   = '0;
            bcnt_d  = '0;
            blim_d  = CNTW'(BACKOFF) << retry_q;
            if (retry_q != 2'd3) begin
              retry_d = retry_q + 2'd1;
            end
          end
        end else begin
          tcnt_d = tcnt_q + CNTW'(1);
        end
      end
      S_BACKOFF: begin
        if (bcnt_q == blim_q - CNTW'(1)) begin
          state_d = S_GATHER;
          tcnt_d  = '0;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + CNTW'(1);
        end
      end
      S_XFER: begin
        req_c = mask_q;
        if (fire) begin
          pop_c  = 1'b1;
          send_c = mask_q;
          if (bus.in_tail) begin
            state_d = S_IDLE;
            mask_d  = '0;
            got_d   = '0;
            retry_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted so nothing is popped or sent mid-reset
  assign bus.req_out    = rst_ ? req_c  : '0;
  assign bus.out_send   = rst_ ? send_c : '0;
  assign bus.in_pop     = rst_ & pop_c;
  assign bus.err_flit   = rst_ & err_c;
  assign bus.busy       = rst_ & (state_q != S_IDLE);
  assign bus.multab_out = rst_ & ((state_q == S_GATHER) || (state_q == S_XFER))
                          & ($countones(mask_q) >= 2);

endmodule
